// File: rtl/bin_to_bcd_stream_conv.sv
// bin_to_bcd_stream_conv
//   Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
//   One binary word is accepted per transaction on a valid/ready input. The
//   NUM_DIGITS packed BCD digits and an overflow flag are returned on a
//   valid/ready output. SHIFTS_PER_CYCLE dabble steps are chained per clock,
//   so a result takes BIN_WIDTH/SHIFTS_PER_CYCLE clocks.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   in_valid/in_ready/bin_in input word handshake
//   out_valid/out_ready      result handshake
//   bcd_out                  packed BCD, digit 0 in [3:0]
//   overflow                 value did not fit in NUM_DIGITS digits
//   busy                     conversion in progress
//   sign_out                 input was negative (BIN2BCD_SIGNED_EN only)
//
// Build option
//   BIN2BCD_SIGNED_EN : treat bin_in as two's complement, convert the
//                       magnitude and report the sign on sign_out.

// One double-dabble step: add 3 to every digit >= 5, then shift {bcd, bin}
// left by one. ovf_o is the bit pushed out of the top digit.
module bin_to_bcd_dabble_step #(
  parameter int BIN_WIDTH  = 32,
  parameter int NUM_DIGITS = 10
) (
  input  logic [NUM_DIGITS*4-1:0] bcd_i,
  input  logic [BIN_WIDTH-1:0]    bin_i,
  output logic [NUM_DIGITS*4-1:0] bcd_o,
  output logic [BIN_WIDTH-1:0]    bin_o,
  output logic                    ovf_o
);
  logic [NUM_DIGITS*4-1:0] adj;

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
    assign adj[d*4 +: 4] = (bcd_i[d*4 +: 4] >= 4'd5) ? bcd_i[d*4 +: 4] + 4'd3
                                                     : bcd_i[d*4 +: 4];
  end

  assign ovf_o = adj[NUM_DIGITS*4-1];
  assign bcd_o = {adj[NUM_DIGITS*4-2:0], bin_i[BIN_WIDTH-1]};
  assign bin_o = {bin_i[BIN_WIDTH-2:0], 1'b0};
endmodule

module bin_to_bcd_stream_conv #(
  parameter int BIN_WIDTH        = 32,
  parameter int NUM_DIGITS       = 10,
  parameter int SHIFTS_PER_CYCLE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BIN_WIDTH-1:0]    bin_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_DIGITS*4-1:0] bcd_out,
  output logic                    overflow,
  output logic                    busy
`ifdef BIN2BCD_SIGNED_EN
  ,
  output logic                    sign_out
`endif
);
  localparam int STEPS = BIN_WIDTH / SHIFTS_PER_CYCLE;
  localparam int CW    = $clog2(STEPS + 1);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if (BIN_WIDTH % SHIFTS_PER_CYCLE != 0) begin : g_bad_spc
    $error("SHIFTS_PER_CYCLE must divide BIN_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;
  state_t state, state_nxt;

  logic [NUM_DIGITS*4-1:0] bcd_acc;
  logic [BIN_WIDTH-1:0]    bin_sr;
  logic                    ovf_acc;
  logic [CW-1:0]           cnt;
  logic [BIN_WIDTH-1:0]    load_val;

  // Combinational chain of SHIFTS_PER_CYCLE steps fed from the working regs.
  logic [SHIFTS_PER_CYCLE:0][NUM_DIGITS*4-1:0] bcd_ch;
  logic [SHIFTS_PER_CYCLE:0][BIN_WIDTH-1:0]    bin_ch;
  logic [SHIFTS_PER_CYCLE-1:0]                 ovf_ch;
  logic                                        step_ovf;
  logic                                        last_step;

  assign bcd_ch[0] = bcd_acc;
  assign bin_ch[0] = bin_sr;

  for (genvar s = 0; s < SHIFTS_PER_CYCLE; s++) begin : g_step
    bin_to_bcd_dabble_step #(
      .BIN_WIDTH (BIN_WIDTH),
      .NUM_DIGITS(NUM_DIGITS)
    ) u_step (
      .bcd_i(bcd_ch[s]),
      .bin_i(bin_ch[s]),
      .bcd_o(bcd_ch[s+1]),
      .bin_o(bin_ch[s+1]),
      .ovf_o(ovf_ch[s])
    );
  end

  assign step_ovf  = |ovf_ch;
  assign last_step = (cnt == LAST);

`ifdef BIN2BCD_SIGNED_EN
  // Negation in BIN_WIDTH bits: the most negative value maps to its own
  // unsigned pattern, which is exactly its magnitude.
  assign load_val = bin_in[BIN_WIDTH-1] ? (~bin_in + 1'b1) : bin_in;
`else
  assign load_val = bin_in;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CONVERT;
      end
      CONVERT: begin
        busy = 1'b1;
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs only capture the final step, so intermediate accumulator
  // values never reach bcd_out/overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcd_acc  <= '0;
      bin_sr   <= '0;
      ovf_acc  <= 1'b0;
      cnt      <= '0;
      bcd_out  <= '0;
      overflow <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
      sign_out <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          bin_sr  <= load_val;
          bcd_acc <= '0;
          ovf_acc <= 1'b0;
          cnt     <= '0;
`ifdef BIN2BCD_SIGNED_EN
          sign_out <= bin_in[BIN_WIDTH-1];
`endif
        end
        CONVERT: begin
          bcd_acc <= bcd_ch[SHIFTS_PER_CYCLE];
          bin_sr  <= bin_ch[SHIFTS_PER_CYCLE];
          ovf_acc <= ovf_acc | step_ovf;
          cnt     <= cnt + CW'(1);
          if (last_step) begin
            bcd_out  <= bcd_ch[SHIFTS_PER_CYCLE];
            overflow <= ovf_acc | step_ovf;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
